fle_lut_ccff_stage: RTL and testbench



---
 rtl/fle_lut_ccff_stage_if.sv | 24 ++
 rtl/fle_lut_ccff_stage.sv | 122 ++++++++++++
 tb/tb_fle_lut_ccff_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fle_lut_ccff_stage_if.sv
// Config-chain and LUT signal bundle for one fle LUT stage.
// The master side feeds chain data and LUT selects; the slave side is the LUT stage itself.
interface fle_lut_ccff_stage_if #(
  parameter int LUT_K = 4
);
  logic             ccff_en;
  logic             ccff_head;
  logic             ccff_tail;
  logic [LUT_K-1:0] lut_in;
  logic             lut_out;
  logic             cfg_bypass;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output ccff_en, ccff_head, lut_in,
    input  ccff_tail, lut_out, cfg_bypass, cfg_done, cfg_err
  );

  modport slave (
    input  ccff_en, ccff_head, lut_in,
    output ccff_tail, lut_out, cfg_bypass, cfg_done, cfg_err
  );
endinterface

// File: rtl/fle_lut_ccff_stage.sv
// K-input LUT feeding the fle flip-flop D input, configured through a serial chain.
// The LUT output stays forced to 0 until a complete, even-parity configuration has been checked.
module fle_lut_ccff_stage #(
  parameter int LUT_K = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fle_lut_ccff_stage_if.slave  bus
);

  localparam int TT_LEN    = 2 ** LUT_K;
  localparam int CHAIN_LEN = TT_LEN + 2;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    UNCFG,
    LOADING,
    CHECK,
    ACTIVE,
    ERROR
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CHAIN_LEN-1:0] chain;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_nxt;

  logic [TT_LEN-1:0]    tt;
  logic                 bypass_bit;
  logic                 parity_ok;

  logic                 lut_out_c;
  logic                 cfg_bypass_c;
  logic                 cfg_done_c;
  logic                 cfg_err_c;

  assign tt         = chain[TT_LEN-1:0];
  assign bypass_bit = chain[CHAIN_LEN-2];
  assign parity_ok  = ~(^chain);

  // The chain shifts in every state so neighbouring segments keep streaming through us.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else if (bus.ccff_en) begin
      chain <= {chain[CHAIN_LEN-2:0], bus.ccff_head};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= UNCFG;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Any shift outside LOADING starts a fresh load; bit_cnt parks at CHAIN_LEN+1 on overrun.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    unique case (state)
      LOADING: begin
        if (bus.ccff_en) begin
          if (bit_cnt != CNT_SAT) begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end else begin
          state_nxt = (bit_cnt == CNT_FULL) ? CHECK : ERROR;
        end
      end
      CHECK: begin
        if (bus.ccff_en) begin
          state_nxt   = LOADING;
          bit_cnt_nxt = CNT_ONE;
        end else begin
          state_nxt = parity_ok ? ACTIVE : ERROR;
        end
      end
      default: begin
        if (bus.ccff_en) begin
          state_nxt   = LOADING;
          bit_cnt_nxt = CNT_ONE;
        end
      end
    endcase
  end

  // Outputs come only from the registered state, so a partial table never reaches ff_D.
  always_comb begin
    lut_out_c    = 1'b0;
    cfg_bypass_c = 1'b0;
    cfg_done_c   = 1'b0;
    cfg_err_c    = 1'b0;
    unique case (state)
      ACTIVE: begin
        cfg_done_c   = 1'b1;
        cfg_bypass_c = bypass_bit;
        lut_out_c    = tt[bus.lut_in];
      end
      ERROR: begin
        cfg_err_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.ccff_tail  = chain[CHAIN_LEN-1];
  assign bus.lut_out    = lut_out_c;
  assign bus.cfg_bypass = cfg_bypass_c;
  assign bus.cfg_done   = cfg_done_c;
  assign bus.cfg_err    = cfg_err_c;

endmodule

// File: tb/tb_fle_lut_ccff_stage.sv
// Bench for fle_lut_ccff_stage: directed scenarios plus random loads against a bit-history model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fle_lut_ccff_stage;

  localparam int LUT_K     = 4;
  localparam int CHAIN_LEN = 18;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   hist[$];

  fle_lut_ccff_stage_if #(.LUT_K(LUT_K)) bus ();

  fle_lut_ccff_stage #(.LUT_K(LUT_K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic model_lut(input logic [15:0] tt, input int idx);
    return logic'((tt >> idx) & 16'd1);
  endfunction

  function automatic logic model_ok(input logic [31:0] bits, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += int'(bits[i]);
    return (n == CHAIN_LEN) && (ones % 2 == 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.ccff_en = 1'b0;
    bus.ccff_head = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
  endtask

  // Shifts n bits MSB first; returns observed and modelled tails (index = shift order) and
  // whether any output was non-zero after a shift edge; leaves ccff_en low at the end.
  task automatic shift_bits(input logic [31:0] bits, input int n, input bit leak_first,
                            output logic [31:0] tails, output logic [31:0] exp_tails,
                            output logic leak);
    leak = 1'b0;
    tails = '0;
    exp_tails = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0 || leak_first)
        leak |= bus.cfg_done | bus.cfg_err | bus.lut_out | bus.cfg_bypass;
      tails[i] = bus.ccff_tail;
      exp_tails[i] = (hist.size() >= CHAIN_LEN) ? logic'(hist[hist.size() - CHAIN_LEN]) : 1'b0;
      bus.ccff_en = 1'b1;
      bus.ccff_head = bits[n-1-i];
      bus.lut_in = 4'($urandom);
      hist.push_back(bits[n-1-i]);
    end
    @(negedge clk);
    leak |= bus.cfg_done | bus.cfg_err | bus.lut_out | bus.cfg_bypass;
    bus.ccff_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.cfg_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", bus.cfg_done); end
    tests_run++; if (bus.cfg_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", bus.cfg_err); end
    tests_run++; if (bus.cfg_bypass !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bypass: got %b expected 0", bus.cfg_bypass); end
    tests_run++; if (bus.lut_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_lut_out: got %b expected 0", bus.lut_out); end
    tests_run++; if (bus.ccff_tail !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tail: got %b expected 0", bus.ccff_tail); end
  endtask

  task automatic test_valid_load();
    logic [31:0] tails, exp_tails;
    logic leak;
    int idx[4] = '{0, 2, 15, 4};
    logic req[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    shift_bits({14'd0, 1'b0, 1'b0, 16'hA5C3}, 18, 1'b0, tails, exp_tails, leak);
    tests_run++; if (leak !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_leak: got %b expected 0", leak); end
    tests_run++; if (tails !== exp_tails) begin tests_failed++; $display("[TB] FAIL valid_tail: got %h expected %h", tails, exp_tails); end
    @(negedge clk);
    tests_run++; if (bus.cfg_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_done_early: got %b expected 0", bus.cfg_done); end
    @(negedge clk);
    tests_run++; if (bus.cfg_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL valid_done: got %b expected 1", bus.cfg_done); end
    tests_run++; if (bus.cfg_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_err: got %b expected 0", bus.cfg_err); end
    tests_run++; if (bus.cfg_bypass !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_bypass: got %b expected 0", bus.cfg_bypass); end
    for (int i = 0; i < 4; i++) begin
      bus.lut_in = 4'(idx[i]);
      #1;
      tests_run++; if (bus.lut_out !== req[i]) begin tests_failed++; $display("[TB] FAIL valid_lut[%0d]: got %b expected %b", idx[i], bus.lut_out, req[i]); end
    end
  endtask

  task automatic test_parity_error();
    logic [31:0] tails, exp_tails;
    logic leak;
    do_reset();
    shift_bits({14'd0, 1'b1, 1'b0, 16'hA5C3}, 18, 1'b0, tails, exp_tails, leak);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (bus.cfg_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL parity_err: got %b expected 1", bus.cfg_err); end
    tests_run++; if (bus.cfg_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL parity_done: got %b expected 0", bus.cfg_done); end
    for (int i = 0; i < 16; i++) begin
      bus.lut_in = 4'(i);
      #1;
      tests_run++; if (bus.lut_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL parity_lut[%0d]: got %b expected 0", i, bus.lut_out); end
    end
  endtask

  task automatic test_length_errors();
    logic [31:0] tails, exp_tails;
    logic leak;
    do_reset();
    shift_bits({15'd0, 1'b0, 16'hA5C3}, 17, 1'b0, tails, exp_tails, leak);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (bus.cfg_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL short_err: got %b expected 1", bus.cfg_err); end
    tests_run++; if (bus.cfg_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL short_done: got %b expected 0", bus.cfg_done); end
    do_reset();
    shift_bits({13'd0, 1'b0, 1'b0, 1'b0, 16'hA5C3}, 19, 1'b0, tails, exp_tails, leak);
    tests_run++; if (dut.bit_cnt !== 5'd19) begin tests_failed++; $display("[TB] FAIL long_bit_cnt: got %0d expected 19", dut.bit_cnt); end
    tests_run++; if (tails[18] !== 1'b0) begin tests_failed++; $display("[TB] FAIL long_tail_first_bit: got %b expected 0", tails[18]); end
    tests_run++; if (tails !== exp_tails) begin tests_failed++; $display("[TB] FAIL long_tail: got %h expected %h", tails, exp_tails); end
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (bus.cfg_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL long_err: got %b expected 1", bus.cfg_err); end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] tails, exp_tails;
    logic leak;
    logic [17:0] cfg = {1'b0, 1'b0, 16'hA5C3};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.ccff_en = 1'b1;
      bus.ccff_head = cfg[17-i];
    end
    @(negedge clk);
    reset = 1'b1;
    bus.ccff_head = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.ccff_en = 1'b0;
    hist.delete();
    tests_run++; if ({bus.cfg_done, bus.cfg_err, bus.cfg_bypass, bus.lut_out} !== 4'b0) begin tests_failed++; $display("[TB] FAIL midreset_outputs: got %b expected 0000", {bus.cfg_done, bus.cfg_err, bus.cfg_bypass, bus.lut_out}); end
    tests_run++; if (bus.ccff_tail !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_tail: got %b expected 0", bus.ccff_tail); end
    tests_run++; if (dut.bit_cnt !== 5'd0) begin tests_failed++; $display("[TB] FAIL midreset_bit_cnt: got %0d expected 0", dut.bit_cnt); end
    shift_bits({14'd0, cfg}, 18, 1'b0, tails, exp_tails, leak);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (bus.cfg_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_reload_done: got %b expected 1", bus.cfg_done); end
  endtask

  task automatic test_reconfigure();
    logic [31:0] tails, exp_tails;
    logic leak;
    logic [17:0] spec_tail = 18'b001010010111000011;
    logic [31:0] req_tail = '0;
    for (int i = 0; i < 18; i++) req_tail[i] = spec_tail[17-i];
    do_reset();
    shift_bits({14'd0, 1'b0, 1'b0, 16'hA5C3}, 18, 1'b0, tails, exp_tails, leak);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (bus.cfg_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL reconf_first_done: got %b expected 1", bus.cfg_done); end
    shift_bits({14'd0, 1'b0, 1'b1, 16'h0001}, 18, 1'b0, tails, exp_tails, leak);
    tests_run++; if (tails !== req_tail) begin tests_failed++; $display("[TB] FAIL reconf_tail_seq: got %h expected %h", tails, req_tail); end
    tests_run++; if (tails !== exp_tails) begin tests_failed++; $display("[TB] FAIL reconf_tail_model: got %h expected %h", tails, exp_tails); end
    tests_run++; if (leak !== 1'b0) begin tests_failed++; $display("[TB] FAIL reconf_leak: got %b expected 0", leak); end
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (bus.cfg_bypass !== 1'b1) begin tests_failed++; $display("[TB] FAIL reconf_bypass: got %b expected 1", bus.cfg_bypass); end
    bus.lut_in = 4'd0;
    #1;
    tests_run++; if (bus.lut_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL reconf_lut0: got %b expected 1", bus.lut_out); end
    bus.lut_in = 4'd1;
    #1;
    tests_run++; if (bus.lut_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reconf_lut1: got %b expected 0", bus.lut_out); end
  endtask

  task automatic test_check_pulse();
    logic [31:0] tails, exp_tails;
    logic leak;
    do_reset();
    shift_bits({14'd0, 1'b0, 1'b0, 16'hA5C3}, 18, 1'b0, tails, exp_tails, leak);
    shift_bits({14'd0, 1'b0, 1'b1, 16'h0001}, 18, 1'b1, tails, exp_tails, leak);
    tests_run++; if (leak !== 1'b0) begin tests_failed++; $display("[TB] FAIL pulse_leak: got %b expected 0", leak); end
    @(negedge clk);
    tests_run++; if ({bus.cfg_done, bus.cfg_err} !== 2'b00) begin tests_failed++; $display("[TB] FAIL pulse_check_outputs: got %b expected 00", {bus.cfg_done, bus.cfg_err}); end
    @(negedge clk);
    tests_run++; if (bus.cfg_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL pulse_done: got %b expected 1", bus.cfg_done); end
    tests_run++; if (bus.cfg_bypass !== 1'b1) begin tests_failed++; $display("[TB] FAIL pulse_bypass: got %b expected 1", bus.cfg_bypass); end
  endtask

  task automatic test_random_loads();
    logic [31:0] tails, exp_tails, bits;
    logic leak, ok, byp, par;
    logic [15:0] tt;
    int n, idx;
    int lens[6] = '{16, 17, 18, 18, 18, 19};
    do_reset();
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      n = lens[$urandom_range(0, 5)];
      tt = 16'($urandom);
      byp = 1'($urandom);
      par = ^{byp, tt};
      if ($urandom_range(0, 3) == 0) par = ~par;
      if (n == CHAIN_LEN) bits = {14'd0, par, byp, tt};
      else bits = $urandom & ((32'd1 << n) - 32'd1);
      ok = model_ok(bits, n);
      shift_bits(bits, n, 1'b0, tails, exp_tails, leak);
      tests_run++; if (tails !== exp_tails) begin tests_failed++; $display("[TB] FAIL rand_tail[%0d]: got %h expected %h", it, tails, exp_tails); end
      tests_run++; if (leak !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_leak[%0d]: got %b expected 0", it, leak); end
      @(negedge clk);
      @(negedge clk);
      tests_run++; if (bus.cfg_done !== ok) begin tests_failed++; $display("[TB] FAIL rand_done[%0d]: got %b expected %b", it, bus.cfg_done, ok); end
      tests_run++; if (bus.cfg_err !== !ok) begin tests_failed++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", it, bus.cfg_err, !ok); end
      tests_run++; if (bus.cfg_bypass !== (ok & byp)) begin tests_failed++; $display("[TB] FAIL rand_bypass[%0d]: got %b expected %b", it, bus.cfg_bypass, ok & byp); end
      for (int j = 0; j < 4; j++) begin
        idx = $urandom_range(0, 15);
        bus.lut_in = 4'(idx);
        #1;
        tests_run++; if (bus.lut_out !== (ok & model_lut(tt, idx))) begin tests_failed++; $display("[TB] FAIL rand_lut[%0d][%0d]: got %b expected %b", it, idx, bus.lut_out, ok & model_lut(tt, idx)); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ccff_en = 1'b0;
    bus.ccff_head = 1'b0;
    bus.lut_in = '0;
    test_reset();
    test_valid_load();
    test_parity_error();
    test_length_errors();
    test_reset_mid_load();
    test_reconfigure();
    test_check_pulse();
    test_random_loads();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
